// File: rtl/gray_pkg.sv
// Shared types and step codes for the Gray-sample receive path.
package gray_pkg;

    typedef enum logic [1:0] {
        INIT,
        TRACK,
        FAULT
    } state_e;

    localparam logic [1:0] STEP_HOLD = 2'b00;
    localparam logic [1:0] STEP_UP   = 2'b01;
    localparam logic [1:0] STEP_DOWN = 2'b11;
    localparam logic [1:0] STEP_BAD  = 2'b10;

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter.
module gray2bin #(
    parameter int W = 4
) (
    input  logic [W-1:0] g,
    output logic [W-1:0] b
);

    // Each binary bit is the XOR of all Gray bits at or above it.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign b[i] = ^(g >> i);
    end

endmodule

// File: rtl/gray_decoder_track.sv
// Gray sample decoder with step classification and wrap-around position.
module gray_decoder_track
    import gray_pkg::*;
#(
    parameter int W  = 4,
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  gray_in,
    input  logic          clear,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  bin_out,
    output logic [1:0]    step,
    output logic [PW-1:0] pos,
    output logic          fault
);

    localparam logic [W-1:0]  D_ONE  = W'(1);
    localparam logic [W-1:0]  D_NEG  = '1;
    localparam logic [PW-1:0] P_ONE  = PW'(1);

    state_e        state_q, state_d, eff_state;
    logic [W-1:0]  prev_q, prev_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          ov_q, ov_d;
    logic [W-1:0]  bin_q, bin_d;
    logic [1:0]    step_q, step_d;
    logic [W-1:0]  bin_w;
    logic [W-1:0]  delta;
    logic          acc;

    gray2bin #(.W(W)) u_g2b (
        .g(gray_in),
        .b(bin_w)
    );

    assign in_ready  = !ov_q || out_ready;
    assign acc       = in_valid && in_ready;
    assign delta     = bin_w - prev_q;
    assign eff_state = clear ? INIT : state_q;

    always_comb begin
        state_d = eff_state;
        prev_d  = prev_q;
        pos_d   = pos_q;
        ov_d    = ov_q;
        bin_d   = bin_q;
        step_d  = step_q;
        if (acc) begin
            ov_d   = 1'b1;
            bin_d  = bin_w;
            step_d = STEP_BAD;
            unique case (eff_state)
                INIT: begin
                    prev_d  = bin_w;
                    state_d = TRACK;
                end
                TRACK: begin
                    prev_d = bin_w;
                    if (delta == '0) begin
                        step_d = STEP_HOLD;
                    end else if (delta == D_ONE) begin
                        step_d = STEP_UP;
                        pos_d  = pos_q + P_ONE;
                    end else if (delta == D_NEG) begin
                        step_d = STEP_DOWN;
                        pos_d  = pos_q - P_ONE;
                    end else begin
                        state_d = FAULT;
                    end
                end
                FAULT: state_d = FAULT;
                default: state_d = INIT;
            endcase
        end else if (out_ready) begin
            ov_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            prev_q  <= '0;
            pos_q   <= '0;
            ov_q    <= 1'b0;
            bin_q   <= '0;
            step_q  <= STEP_HOLD;
        end else begin
            state_q <= state_d;
            prev_q  <= prev_d;
            pos_q   <= pos_d;
            ov_q    <= ov_d;
            bin_q   <= bin_d;
            step_q  <= step_d;
        end
    end

    assign out_valid = ov_q;
    assign bin_out   = bin_q;
    assign step      = step_q;
    assign pos       = pos_q;
    assign fault     = (state_q == FAULT);

endmodule

// File: tb/tb_gray_decoder_track.sv
// Vector table, directed corner sequences and randomized model check.
module tb_gray_decoder_track;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] gray_in = 4'd0;
    logic       clear = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] bin_out;
    logic [1:0] step;
    logic [7:0] pos;
    logic       fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    gray_decoder_track #(.W(4), .PW(8)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .gray_in(gray_in),
        .clear(clear),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .bin_out(bin_out),
        .step(step),
        .pos(pos),
        .fault(fault)
    );

    typedef struct {
        logic       rs;
        logic       iv;
        logic       cl;
        logic [3:0] g;
        logic [3:0] eb;
        logic [1:0] es;
        logic [7:0] ep;
        logic       ef;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        clear = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic send(input logic [3:0] g);
        in_valid = 1'b1;
        gray_in = g;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b = g;
        for (int k = 1; k < 4; k++) b = b ^ (g >> k);
        return b;
    endfunction

    // reference model state
    logic       m_need_ref, m_faulted, m_ov;
    logic [3:0] m_prev, m_bin;
    logic [1:0] m_step;
    int         m_pos;

    task automatic model_reset();
        m_need_ref = 1'b1;
        m_faulted = 1'b0;
        m_ov = 1'b0;
        m_prev = 4'd0;
        m_bin = 4'd0;
        m_step = 2'b00;
        m_pos = 0;
    endtask

    task automatic model_edge(input logic acc, input logic clr,
                              input logic [3:0] g, input logic ordy);
        logic [3:0] b;
        int d;
        if (clr) begin
            m_need_ref = 1'b1;
            m_faulted = 1'b0;
        end
        if (acc) begin
            b = g2b(g);
            m_ov = 1'b1;
            m_bin = b;
            m_step = 2'b10;
            if (!m_faulted) begin
                if (m_need_ref) begin
                    m_need_ref = 1'b0;
                end else begin
                    d = (int'(b) - int'(m_prev) + 16) % 16;
                    if (d == 0) m_step = 2'b00;
                    else if (d == 1) begin
                        m_step = 2'b01;
                        m_pos = (m_pos + 1) % 256;
                    end else if (d == 15) begin
                        m_step = 2'b11;
                        m_pos = (m_pos + 255) % 256;
                    end else m_faulted = 1'b1;
                end
                m_prev = b;
            end
        end else if (ordy) begin
            m_ov = 1'b0;
        end
    endtask

    initial begin
        logic [3:0] lastb, tb_b;
        logic       m_rdy, acc, iv, cl;
        int         r;

        // rs iv cl gray  bin step pos fault
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'b0000, 4'd0, 2'b10, 8'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0001, 4'd1, 2'b01, 8'd1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0011, 4'd2, 2'b01, 8'd2, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0010, 4'd3, 2'b01, 8'd3, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0010, 4'd3, 2'b00, 8'd3, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0011, 4'd2, 2'b11, 8'd2, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'b0000, 4'd0, 2'b10, 8'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b1000, 4'd15, 2'b11, 8'hFF, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b1001, 4'd14, 2'b11, 8'hFE, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b1000, 4'd15, 2'b01, 8'hFF, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0000, 4'd0, 2'b01, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 4'b0000, 4'd0, 2'b10, 8'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0110, 4'd4, 2'b10, 8'd0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0111, 4'd5, 2'b10, 8'd0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 4'b0000, 4'd0, 2'b00, 8'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0101, 4'd6, 2'b10, 8'd0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0100, 4'd7, 2'b01, 8'd1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0000, 4'd0, 2'b10, 8'd1, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 4'b0001, 4'd1, 2'b10, 8'd1, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 4'b0011, 4'd2, 2'b01, 8'd2, 1'b0});

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ov", out_valid, 0);
        chk("rst_bin", bin_out, 0);
        chk("rst_step", step, 0);
        chk("rst_pos", pos, 0);
        chk("rst_fault", fault, 0);
        chk("rst_rdy", in_ready, 1);

        out_ready = 1'b1;
        foreach (tbl[i]) begin
            if (tbl[i].rs) do_reset();
            in_valid = tbl[i].iv;
            gray_in = tbl[i].g;
            clear = tbl[i].cl;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            clear = 1'b0;
            chk($sformatf("v%0d_ov", i), out_valid, tbl[i].iv);
            if (tbl[i].iv) begin
                chk($sformatf("v%0d_bin", i), bin_out, tbl[i].eb);
                chk($sformatf("v%0d_step", i), step, tbl[i].es);
            end
            chk($sformatf("v%0d_pos", i), pos, tbl[i].ep);
            chk($sformatf("v%0d_fault", i), fault, tbl[i].ef);
        end

        // backpressure
        do_reset();
        send(4'b0000);
        out_ready = 1'b0;
        in_valid = 1'b1;
        gray_in = 4'b0001;
        #1;
        chk("bp_rdy0", in_ready, 0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("bp_rdy", in_ready, 0);
            chk("bp_ov", out_valid, 1);
            chk("bp_bin", bin_out, 0);
            chk("bp_step", step, 2'b10);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_rdy", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_nx_ov", out_valid, 1);
        chk("bp_nx_bin", bin_out, 1);
        chk("bp_nx_step", step, 2'b01);
        chk("bp_nx_pos", pos, 1);
        @(posedge clk);
        #1;
        chk("bp_nodup", out_valid, 0);
        chk("bp_nodup_pos", pos, 1);

        // reset mid-stream
        do_reset();
        send(4'b0000);
        send(4'b0001);
        send(4'b0011);
        send(4'b0010);
        chk("mr_pre_pos", pos, 3);
        chk("mr_pre_ov", out_valid, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mr_ov", out_valid, 0);
        chk("mr_pos", pos, 0);
        chk("mr_fault", fault, 0);
        send(4'b0001);
        chk("mr_first_bin", bin_out, 1);
        chk("mr_first_step", step, 2'b10);
        chk("mr_first_pos", pos, 0);

        // randomized check against the model
        do_reset();
        model_reset();
        lastb = 4'd0;
        for (int n = 0; n < 600; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            iv = ($urandom_range(0, 3) != 0);
            cl = ($urandom_range(0, 24) == 0);
            r = $urandom_range(0, 9);
            if (r < 4) tb_b = lastb + 4'd1;
            else if (r < 7) tb_b = lastb - 4'd1;
            else if (r == 7) tb_b = lastb;
            else tb_b = 4'($urandom_range(0, 15));
            lastb = tb_b;
            in_valid = iv;
            clear = cl;
            gray_in = tb_b ^ (tb_b >> 1);
            m_rdy = !m_ov || out_ready;
            acc = iv && m_rdy;
            #1;
            chk("rnd_rdy", in_ready, m_rdy);
            @(posedge clk);
            model_edge(acc, cl, gray_in, out_ready);
            #1;
            chk("rnd_ov", out_valid, m_ov);
            chk("rnd_bin", bin_out, m_bin);
            chk("rnd_step", step, m_step);
            chk("rnd_pos", pos, 32'(m_pos));
            chk("rnd_fault", fault, m_faulted);
        end
        in_valid = 1'b0;
        clear = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
